serial_frame_receiver: RTL and testbench
========================================

// Module: serial_frame_receiver
// PURPOSE
//   Serial-in/parallel-out frame receiver; the receive end of the team's serial byte link.
//   Samples serial_in once per clk rising edge (clk is the bit clock; no oversampling).
//   Detects a start bit, shifts in DATA_W data bits MSB first, checks the stop bit.
//   Presents the byte on data_out with a one-cycle data_valid strobe.
//   Frame on the line: idle=1, start=0, DATA_W data bits MSB first, [parity], stop=1.
// PARAMETERS
//   DATA_W   8   data bits per frame; legal range 2..16
// PORTS
//   clk         in   1        bit clock; all state changes on rising edge
//   reset       in   1        asynchronous, active-high
//   serial_in   in   1        serial line; idles high
//   data_out    out  DATA_W   last correctly received word; held until next good frame
//   data_valid  out  1        1-cycle pulse: data_out just updated
//   frame_err   out  1        1-cycle pulse: bad stop bit (or parity, see CONFIGURATION)
//   busy        out  1        1 while in any state other than IDLE
// BEHAVIOUR
//   - Reset value of every output: data_out=0, data_valid=0, frame_err=0, busy=0; state=IDLE.
//   - Reset is asynchronous: it aborts a frame mid-way; no partial data reaches data_out.
//   - FSM states and transitions:
//       IDLE --(serial_in==0 at edge)--> DATA, bit_cnt=0.
//       DATA: each edge, shreg <= {shreg[DATA_W-2:0], serial_in}, bit_cnt++.
//             After the DATA_W-th bit --> STOP (or PARITY when enabled).
//       STOP: serial_in==1 -> data_out<=shreg, data_valid=1; serial_in==0 -> frame_err=1.
//             Either result --> IDLE.
//   - A 0 sampled in STOP is not treated as a new start bit.
//   - Timing: start bit sampled at edge E. Data bits are sampled at E+1..E+DATA_W.
//     The stop bit is sampled at E+DATA_W+1; data_valid/frame_err are high in the cycle after that edge.
//     The earliest next start bit is sampled at E+DATA_W+2 (back-to-back frames supported).
//   - data_valid and frame_err are mutually exclusive and never high for more than 1 cycle.
//   - bit_cnt width: $clog2(DATA_W+1); it wraps to 0 on entry to DATA and never overflows.
//   - busy = (state != IDLE); combinational from the state register.
//   - A line stuck at 0: frame, frame_err, IDLE, then restart on the next 0 sample.
// CONFIGURATION
//   SERIAL_RX_PARITY_EN defined:
//     - Adds a PARITY state between DATA and STOP that samples one odd-parity bit.
//     - Parity is correct when the XOR of the data bits and the parity bit is 1.
//     - On a parity mismatch, the stop-bit check still runs; frame_err pulses and data_out is not updated.
//     - All timing after the data bits shifts by +1 cycle.
//   SERIAL_RX_PARITY_EN undefined: no PARITY state; the frame is exactly DATA_W+2 bits.
// STRUCTURE
//   serial_pkg (shared with the transmitter):
//     - rx_state_t enum {IDLE, DATA, PARITY, STOP};
//     - START_BIT=1'b0, STOP_BIT=1'b1, IDLE_LEVEL=1'b1;
//     - default width constant SER_DATA_W=8.
//   One sub-module: sipo_shift_reg (DATA_W bits; shift_en, serial_in -> q), async reset to 0.
//   The FSM, bit counter, parity accumulator and output registers live in the top.
// TESTING
//   1. Idle high for 20 cycles -> busy=0, data_valid=0, frame_err=0, data_out=0.
//   2. Frame 0,1,0,1,0,0,1,0,1,1 (0xA5) -> data_out=8'hA5; data_valid pulses 1 cycle after the stop edge.
//   3. Frames 0x00 and 0xFF back-to-back, no idle gap -> two valid pulses 10 cycles apart,
//      with data_out 0x00 then 0xFF.
//   4. Frame 0x3C with stop=0 -> frame_err pulse, data_out keeps its previous value, FSM returns to IDLE.
//   5. Assert reset after the 4th data bit -> all outputs 0 at once; a following 0x81 frame is received cleanly.
//   6. [PARITY_EN] 0x07 with parity=0 -> data_valid; 0x07 with parity=1 -> frame_err, data_out unchanged.

Source files
------------

// File: rtl/serial_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_pkg
// Description : Shared definitions for the serial byte link (receiver and
//               transmitter): receiver state encoding, line levels and the
//               default data width.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_pkg;

    // Receiver FSM states, explicit 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    localparam int SER_DATA_W = 8;

endpackage : serial_pkg
`default_nettype wire

// File: rtl/serial_frame_receiver_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_frame_receiver_if
// Description : Bundle of the receiver's line input and parallel outputs.
//               master : line driver / consumer side (drives serial_in)
//               slave  : receiver side (drives data_out, data_valid,
//                        frame_err, busy)
// Ports       : serial_in, data_out[DATA_W], data_valid, frame_err, busy
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_frame_receiver_if
    import serial_pkg::*;
#(
    parameter int DATA_W = SER_DATA_W
) ();

    logic              serial_in;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              frame_err;
    logic              busy;

    modport master (
        output serial_in,
        input  data_out,
        input  data_valid,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  serial_in,
        output data_out,
        output data_valid,
        output frame_err,
        output busy
    );

endinterface : serial_frame_receiver_if
`default_nettype wire

// File: rtl/sipo_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : sipo_shift_reg
// Description : Serial-in / parallel-out shift register, MSB first. When
//               shift_en_i is high the register shifts left and serial_in_i
//               enters at bit 0, so after DATA_W shifts the first bit received
//               sits in the MSB.
// Ports       : clk, reset (async, active-high), shift_en_i, serial_in_i,
//               q_o[DATA_W]
// Revision    : 1.0 - initial release
// ============================================================================
module sipo_shift_reg #(
    parameter int DATA_W = 8
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              shift_en_i,
    input  wire logic              serial_in_i,
    output      logic [DATA_W-1:0] q_o
);

    logic [DATA_W-1:0] shreg_q;
    logic [DATA_W-1:0] shreg_d;

    always_comb begin
        shreg_d = shreg_q;
        if (shift_en_i) begin
            shreg_d = {shreg_q[DATA_W-2:0], serial_in_i};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign q_o = shreg_q;

endmodule : sipo_shift_reg
`default_nettype wire

// File: rtl/serial_frame_receiver.sv
`default_nettype none
// ============================================================================
// Module      : serial_frame_receiver
// Description : Receive end of the serial byte link. Samples serial_in once
//               per clk rising edge, detects the start bit, shifts in DATA_W
//               data bits MSB first, checks the stop bit and presents the word
//               on data_out with a one-cycle data_valid strobe; a bad stop bit
//               gives a one-cycle frame_err strobe instead.
//               Line frame: idle=1, start=0, DATA_W data bits, [parity], stop=1.
// Config      : define SERIAL_RX_PARITY_EN to add an odd-parity bit between
//               the data bits and the stop bit.
// Ports       : clk, reset (async, active-high),
//               bus (serial_frame_receiver_if.slave): serial_in, data_out,
//               data_valid, frame_err, busy
// Revision    : 1.0 - initial release
// ============================================================================
module serial_frame_receiver
    import serial_pkg::*;
#(
    parameter int DATA_W = SER_DATA_W
) (
    input wire logic                clk,
    input wire logic                reset,
    serial_frame_receiver_if.slave  bus
);

    localparam int                CNT_W      = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0]  c_cnt_last = CNT_W'(DATA_W - 1);

    rx_state_t         state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              data_valid_q, data_valid_d;
    logic              frame_err_q, frame_err_d;
    logic [DATA_W-1:0] w_shreg;
    logic              w_shift_en;
    logic              w_parity_ok;
    rx_state_t         w_after_data;

    // ------------------------------------------------------------------
    // Data shift register: shifts exactly once per data-bit cycle.
    // ------------------------------------------------------------------
    assign w_shift_en = (state_q == DATA);

    sipo_shift_reg #(
        .DATA_W (DATA_W)
    ) u_sipo (
        .clk         (clk),
        .reset       (reset),
        .shift_en_i  (w_shift_en),
        .serial_in_i (bus.serial_in),
        .q_o         (w_shreg)
    );

    // ------------------------------------------------------------------
    // Optional odd-parity accumulator. It starts at 0 in IDLE and XORs in
    // every data bit plus the parity bit, so a correct frame leaves it at 1
    // by the time the stop bit is sampled.
    // ------------------------------------------------------------------
`ifdef SERIAL_RX_PARITY_EN
    logic parity_q, parity_d;

    always_comb begin
        parity_d = parity_q;
        case (state_q)
            IDLE:         parity_d = 1'b0;
            DATA, PARITY: parity_d = parity_q ^ bus.serial_in;
            default:      parity_d = parity_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign w_parity_ok  = parity_q;
    assign w_after_data = PARITY;
`else
    assign w_parity_ok  = 1'b1;
    assign w_after_data = STOP;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic. A 0 seen in STOP is a framing error, not a
    // new start bit; the start is only recognised from IDLE.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.serial_in == START_BIT) state_d = DATA;
            DATA:    if (bit_cnt_q == c_cnt_last)    state_d = w_after_data;
            PARITY:  state_d = STOP;
            STOP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs and datapath next values. The strobes are registered so
    // they appear in the cycle after the stop-bit edge.
    // ------------------------------------------------------------------
    always_comb begin
        bit_cnt_d    = bit_cnt_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        case (state_q)
            IDLE: bit_cnt_d = '0;
            DATA: bit_cnt_d = bit_cnt_q + CNT_W'(1);
            STOP: begin
                if ((bus.serial_in == STOP_BIT) && w_parity_ok) begin
                    data_out_d   = w_shreg;
                    data_valid_d = 1'b1;
                end else begin
                    frame_err_d  = 1'b1;
                end
            end
            default: bit_cnt_d = bit_cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt_q    <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            bit_cnt_q    <= bit_cnt_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.data_valid = data_valid_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.busy       = (state_q != IDLE);

endmodule : serial_frame_receiver
`default_nettype wire

// File: tb/tb_serial_frame_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_frame_receiver
// Description : Self-checking bench for serial_frame_receiver. Frames are
//               driven bit by bit; every frame schedules its expected result
//               (cycle of the strobe, kind, data_out) in a scoreboard, and
//               every cycle the strobes and data_out are compared against it.
//               Directed frames come from a vector table, random frames from a
//               frame-level model (stop=1 -> data word, else error, keep word).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_frame_receiver;
    import serial_pkg::*;

    localparam int DW = 8;
`ifdef SERIAL_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    typedef struct {
        logic [DW-1:0] data;
        logic          stop;
        int            gap;
        logic          exp_valid;
        logic          exp_err;
        logic [DW-1:0] exp_dout;
    } vec_t;

    typedef struct {
        int            cyc;
        logic          valid;
        logic          err;
        logic [DW-1:0] dout;
    } evt_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;

    evt_t          sb[$];
    logic [DW-1:0] model_dout = '0;
    logic [DW-1:0] last_dout  = '0;
    int            n_tests    = 0;
    int            n_fail     = 0;

    serial_frame_receiver_if #(.DATA_W(DW)) bus_if ();

    serial_frame_receiver #(.DATA_W(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called on every falling edge: compare strobes and data_out to the
    // scoreboard entry due this cycle (or to "no strobe" if none is due).
    task automatic monitor_step();
        evt_t e;
        if (sb.size() > 0 && sb[0].cyc < cyc) begin
            check("sb_overdue", 32'(sb[0].cyc), 32'(cyc));
            void'(sb.pop_front());
        end
        e.cyc = cyc; e.valid = 1'b0; e.err = 1'b0; e.dout = model_dout;
        if (sb.size() > 0 && sb[0].cyc == cyc) e = sb.pop_front();
        model_dout = e.dout;
        check("data_valid", 32'(bus_if.data_valid), 32'(e.valid));
        check("frame_err",  32'(bus_if.frame_err),  32'(e.err));
        check("data_out",   32'(bus_if.data_out),   32'(model_dout));
    endtask

    task automatic drive_bit(input logic b);
        @(negedge clk);
        monitor_step();
        bus_if.serial_in = b;
    endtask

    task automatic idle(input int n);
        repeat (n) drive_bit(IDLE_LEVEL);
    endtask

    // Drive a full frame. The start bit is sampled at the next rising edge
    // (cycle E = cyc+1); the result is visible after edge E+DW+PB+1.
    task automatic send_frame(input logic [DW-1:0] data, input logic stop, input logic par,
                              input logic ev, input logic ee, input logic [DW-1:0] ed);
        evt_t e;
        drive_bit(START_BIT);
        e.cyc = cyc + DW + PB + 2; e.valid = ev; e.err = ee; e.dout = ed;
        sb.push_back(e);
        last_dout = ed;
        for (int i = DW - 1; i >= 0; i--) drive_bit(data[i]);
        if (PB != 0) drive_bit(par);
        drive_bit(stop);
    endtask

    function automatic logic odd_par(input logic [DW-1:0] d);
        return ~(^d);
    endfunction

    vec_t vecs[4];

    initial begin
        logic [DW-1:0] rd;
        logic          rs;
        int            rg;

        vecs[0] = '{data: 8'hA5, stop: 1'b1, gap: 3, exp_valid: 1'b1, exp_err: 1'b0, exp_dout: 8'hA5};
        vecs[1] = '{data: 8'h00, stop: 1'b1, gap: 0, exp_valid: 1'b1, exp_err: 1'b0, exp_dout: 8'h00};
        vecs[2] = '{data: 8'hFF, stop: 1'b1, gap: 2, exp_valid: 1'b1, exp_err: 1'b0, exp_dout: 8'hFF};
        vecs[3] = '{data: 8'h3C, stop: 1'b0, gap: 3, exp_valid: 1'b0, exp_err: 1'b1, exp_dout: 8'hFF};

        // Reset and idle-line behaviour.
        bus_if.serial_in = IDLE_LEVEL;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data_out", 32'(bus_if.data_out), 32'h0);
        check("rst_busy",     32'(bus_if.busy),     32'h0);
        reset = 1'b0;
        idle(20);
        check("idle_busy", 32'(bus_if.busy), 32'h0);

        // Directed table: 0xA5, back-to-back 0x00/0xFF, bad stop on 0x3C.
        for (int v = 0; v < 4; v++) begin
            send_frame(vecs[v].data, vecs[v].stop, odd_par(vecs[v].data),
                       vecs[v].exp_valid, vecs[v].exp_err, vecs[v].exp_dout);
            idle(vecs[v].gap);
        end
        check("busy_after_err", 32'(bus_if.busy), 32'h0);

        // Asynchronous reset after the 4th data bit.
        drive_bit(START_BIT);
        drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b0); drive_bit(1'b0);
        @(posedge clk); #1;
        check("busy_midframe", 32'(bus_if.busy), 32'h1);
        reset = 1'b1;
        bus_if.serial_in = IDLE_LEVEL;
        #1;
        check("arst_data_out",   32'(bus_if.data_out),   32'h0);
        check("arst_data_valid", 32'(bus_if.data_valid), 32'h0);
        check("arst_frame_err",  32'(bus_if.frame_err),  32'h0);
        check("arst_busy",       32'(bus_if.busy),       32'h0);
        sb.delete();
        model_dout = '0;
        last_dout  = '0;
        @(negedge clk);
        reset = 1'b0;
        idle(2);
        send_frame(8'h81, 1'b1, odd_par(8'h81), 1'b1, 1'b0, 8'h81);
        idle(3);

`ifdef SERIAL_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0, 1'b1, 1'b0, 8'h07);
        idle(2);
        send_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b1, 8'h07);
        idle(2);
`endif

        // Random frames against the frame-level model.
        for (int k = 0; k < 40; k++) begin
            rd = DW'($urandom);
            rs = ($urandom_range(0, 3) != 0);
            rg = $urandom_range(0, 2);
            if (rs) send_frame(rd, 1'b1, odd_par(rd), 1'b1, 1'b0, rd);
            else    send_frame(rd, 1'b0, odd_par(rd), 1'b0, 1'b1, last_dout);
            idle(rg);
        end

        idle(DW + 4);
        check("sb_drained", 32'(sb.size()), 32'h0);
        check("final_busy", 32'(bus_if.busy), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_serial_frame_receiver
`default_nettype wire
